// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side FIFO controller presenting fixed-length bursts on a valid/ready stream
//
// Pops words from a synchronous FIFO (one-cycle read latency) and delivers
// them on a valid/ready stream in bursts of BURST_LEN beats with a last marker.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   enable             permits a new burst to start (checked at burst boundaries)
//   fifo_empty         FIFO empty flag
//   fifo_data_out      FIFO read data, valid the cycle after a pop
//   fifo_read_en       FIFO pop request
//   m_data/m_valid     stream beat
//   m_ready            consumer accepts the beat
//   m_last             final beat of a burst
//   word_count         total beats delivered, wraps at 2^16
//   busy               controller is not idle

`timescale 1ns/1ps

module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [15:0]      word_count,
    output logic             busy
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [15:0]       word_count_q, word_count_d;
    logic [WIDTH-1:0]  buf0_q, buf0_d;   // head of the output buffer
    logic [WIDTH-1:0]  buf1_q, buf1_d;

    logic              stream_pop;
    logic              fifo_pop;
    logic [2:0]        pending;

    always_comb begin
        stream_pop = (occ_q != 2'd0) && m_ready;
        pending    = {1'b0, occ_q} + {2'b00, inflight_q};
        // Words already held or on their way, minus the one leaving now, must
        // leave room in the 2-entry buffer for the word this pop would return.
        fifo_pop   = (state_q == BURST) && !fifo_empty &&
                     (pending < (3'd2 + {2'b00, stream_pop}));

        state_d      = state_q;
        issued_d     = issued_q;
        inflight_d   = fifo_pop;
        occ_d        = occ_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        beat_d       = beat_q;
        word_count_d = word_count_q;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d  = BURST;
                    issued_d = '0;
                end
            end
            BURST: begin
                if (fifo_pop) begin
                    if (issued_q == LAST_IDX) begin
                        issued_d = '0;
                        if (!enable) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        issued_d = issued_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A word is only ever in flight when the buffer has room for it, so
        // capture never sees occ == 2.
        case ({inflight_q, stream_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf1_d = fifo_data_out;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_out;
                end
            end
            default: ;
        endcase

        if (stream_pop) begin
            word_count_d = word_count_q + 16'd1;
            beat_d       = (beat_q == LAST_IDX) ? '0 : beat_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            issued_q     <= '0;
            beat_q       <= '0;
            word_count_q <= 16'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            issued_q     <= issued_d;
            beat_q       <= beat_d;
            word_count_q <= word_count_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
        end
    end

    assign fifo_read_en = fifo_pop;
    assign m_valid      = (occ_q != 2'd0);
    assign m_data       = buf0_q;
    assign m_last       = m_valid && (beat_q == LAST_IDX);
    assign word_count   = word_count_q;
    assign busy         = (state_q != IDLE);

endmodule
